// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit adder walks across WIDTH-bit operands,
// rippling a registered carry between digits, with valid/ready handshakes on both sides.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [31:0]      w_base;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_dsum;
  logic             w_last;
  logic             w_accept;

  assign w_base   = DIGIT * {{(32-CW){1'b0}}, r_cnt};
  assign w_a_dig  = r_a[w_base +: DIGIT];
  assign w_b_dig  = r_bx[w_base +: DIGIT];
  assign w_dsum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_last   = (r_cnt == LastCnt);
  assign w_accept = i_in_valid && o_in_ready;

  // in_ready is the only combinational output; it drops while reset is asserted.
  assign o_in_ready  = !i_rst && (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_overflow  = r_ovf;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (i_out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_bx    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a     <= i_a;
            r_bx    <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_cnt   <= '0;
          end
        end
        StRun: begin
          r_sum[w_base +: DIGIT] <= w_dsum[DIGIT-1:0];
          r_carry                <= w_dsum[DIGIT];
          r_cnt                  <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout <= w_dsum[DIGIT];
            // Signed overflow: operands agree in sign but the result sign differs.
            r_ovf  <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (w_dsum[DIGIT-1] != r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
